// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller.
//   dmem_state_e : controller states (IDLE, RD, WR, DONE)
//   SIZE_*       : encodings of the MEM store size field
//   TMO_CNT_W    : width of the request timeout counter
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } dmem_state_e;

  localparam logic [1:0] SIZE_WORD = 2'd0;
  localparam logic [1:0] SIZE_BYTE = 2'd1;
  localparam logic [1:0] SIZE_HALF = 2'd2;

  localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/dmem_store_merge.sv
// Combinational store merge for read-modify-write of sub-word stores.
// Lanes are big-endian: offset 0 is bits [31:24], offset 3 is bits [7:0].
//   old_word : word read back from memory
//   data     : store data, byte in [7:0], half in [15:0]
//   offset   : byte address bits [1:0]
//   size     : SIZE_WORD / SIZE_BYTE / SIZE_HALF (reserved code acts as word)
//   merged   : word to write back
module dmem_store_merge
  import dmem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (size)
      SIZE_BYTE: begin
        case (offset)
          2'd0:    merged[31:24] = data[7:0];
          2'd1:    merged[23:16] = data[7:0];
          2'd2:    merged[15:8]  = data[7:0];
          default: merged[7:0]   = data[7:0];
        endcase
      end
      SIZE_HALF: begin
        // offset[0] is never set here; misaligned halves are rejected upstream
        if (offset[1]) merged[15:0]  = data[15:0];
        else           merged[31:16] = data[15:0];
      end
      default: merged = data;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller between the MEM stage and a variable-latency
// memory with a req/ack handshake. Sub-word stores are done as
// read-modify-write; the pipeline is stalled until each access completes.
//   CLK, RESET       : clock, asynchronous active-high reset
//   MemRead_IN/MemWrite_IN, Address_IN, WriteData_IN, WriteSize_IN : MEM request
//   ReadData_OUT     : aligned word from the last successful read
//   Stall_OUT        : hold MEM inputs stable
//   Error_OUT        : one-cycle pulse on timeout or misaligned half store
//   mem_req, mem_we, mem_addr, mem_wdata : registered memory request
//   mem_ack, mem_rdata                   : memory completion strobe and data
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemRead_IN,
  input  logic        MemWrite_IN,
  input  logic [31:0] Address_IN,
  input  logic [31:0] WriteData_IN,
  input  logic [1:0]  WriteSize_IN,
  output logic [31:0] ReadData_OUT,
  output logic        Stall_OUT,
  output logic        Error_OUT,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  dmem_state_e          state, state_n;
  logic [TMO_CNT_W-1:0] cnt;
  logic                 rmw_p0;
  logic [1:0]           off_p0;
  logic [1:0]           size_p0;
  logic [31:0]          data_p0;
  logic [31:0]          merged;
  logic                 start;
  logic                 misal;
  logic                 tmo;
  logic                 sub_word;

  assign sub_word = (WriteSize_IN == SIZE_BYTE) || (WriteSize_IN == SIZE_HALF);

  dmem_store_merge u_merge (
    .old_word (mem_rdata),
    .data     (data_p0),
    .offset   (off_p0),
    .size     (size_p0),
    .merged   (merged)
  );

  // Stall is forced low while reset is held so an aborted access releases
  // the pipeline without waiting for a clock.
  assign Stall_OUT = !RESET &&
                     (((state == IDLE) && (MemRead_IN || MemWrite_IN)) ||
                      (state == RD) || (state == WR));

  always_comb begin
    state_n = state;
    start   = 1'b0;
    misal   = 1'b0;
    tmo     = 1'b0;
    case (state)
      IDLE: begin
        if (MemWrite_IN) begin
          start = 1'b1;
          if ((WriteSize_IN == SIZE_HALF) && Address_IN[0]) begin
            misal   = 1'b1;
            state_n = DONE;
          end else if (sub_word) begin
            state_n = RD;
          end else begin
            state_n = WR;
          end
        end else if (MemRead_IN) begin
          start   = 1'b1;
          state_n = RD;
        end
      end
      RD: begin
        if (mem_ack) begin
          state_n = rmw_p0 ? WR : DONE;
        end else if (cnt == TMO_LAST) begin
          tmo     = 1'b1;
          state_n = DONE;
        end
      end
      WR: begin
        if (mem_ack) begin
          state_n = DONE;
        end else if (cnt == TMO_LAST) begin
          tmo     = 1'b1;
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt          <= '0;
      rmw_p0       <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      ReadData_OUT <= '0;
      Error_OUT    <= 1'b0;
    end else begin
      // Request outputs follow the next state, so they are stable for the
      // whole phase and drop in the cycle after ack or timeout.
      mem_req   <= (state_n == RD) || (state_n == WR);
      mem_we    <= (state_n == WR);
      Error_OUT <= misal | tmo;
      if (state_n != state)                 cnt <= '0;
      else if ((state == RD) || (state == WR)) cnt <= cnt + 1'b1;
      if (start && !misal) begin
        rmw_p0   <= MemWrite_IN;
        mem_addr <= {Address_IN[31:2], 2'b00};
        if (state_n == WR) mem_wdata <= WriteData_IN;
      end
      if ((state == RD) && mem_ack) begin
        if (rmw_p0) mem_wdata    <= merged;
        else        ReadData_OUT <= mem_rdata;
      end
    end
  end

  // Request fields used by the merge; data only, no reset needed.
  always_ff @(posedge CLK) begin
    if (start) begin
      off_p0  <= Address_IN[1:0];
      size_p0 <= WriteSize_IN;
      data_p0 <= WriteData_IN;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MemRead_IN, MemWrite_IN;
  logic [31:0] Address_IN, WriteData_IN;
  logic [1:0]  WriteSize_IN;
  logic [31:0] ReadData_OUT;
  logic        Stall_OUT, Error_OUT;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 CLK = ~CLK;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .MemRead_IN   (MemRead_IN),
    .MemWrite_IN  (MemWrite_IN),
    .Address_IN   (Address_IN),
    .WriteData_IN (WriteData_IN),
    .WriteSize_IN (WriteSize_IN),
    .ReadData_OUT (ReadData_OUT),
    .Stall_OUT    (Stall_OUT),
    .Error_OUT    (Error_OUT),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Memory behind the DUT (written only by the responder) and the reference
  // memory (written only by the stimulus process).
  logic [31:0] mem     [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] ref_rdata;

  function automatic logic [31:0] seed_word(logic [29:0] i);
    if (i == 30'(32'h1004 >> 2)) return 32'hDEADBEEF;
    if (i == 30'(32'h2000 >> 2)) return 32'h11223344;
    if (i == 30'(32'h3000 >> 2)) return 32'h11223344;
    return {i[15:0], ~i[15:0]} ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] mem_get(logic [29:0] i);
    if (mem.exists(i)) return mem[i];
    return seed_word(i);
  endfunction

  function automatic logic [31:0] ref_get(logic [29:0] i);
    if (ref_mem.exists(i)) return ref_mem[i];
    return seed_word(i);
  endfunction

  function automatic logic [31:0] ref_merge(logic [31:0] old, logic [31:0] d,
                                            logic [1:0] off, logic [1:0] sz);
    int sh;
    logic [31:0] m;
    if (sz == SIZE_BYTE) begin
      sh = 8 * (3 - int'(off));
      m  = 32'h000000FF << sh;
    end else if (sz == SIZE_HALF) begin
      sh = off[1] ? 0 : 16;
      m  = 32'h0000FFFF << sh;
    end else begin
      return d;
    end
    return (old & ~m) | ((d << sh) & m);
  endfunction

  // Memory responder: acks after wt[phase] wait cycles of req.
  int          wt [2];
  int          ph, wcnt;
  int          rd_acks = 0, wr_acks = 0, bad_addr = 0;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] wr_addr_seen = 32'h0, wr_data_seen = 32'h0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    ph        = 0;
    wcnt      = 0;
    forever begin
      @(negedge CLK);
      if (!mem_req) begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        ph        = 0;
        wcnt      = 0;
      end else begin
        if (mem_addr !== exp_addr) bad_addr++;
        if (mem_ack) begin
          mem_ack = 1'b0;
          ph      = 1;
          wcnt    = 0;
        end
        if (wcnt == wt[ph]) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem[mem_addr[31:2]] = mem_wdata;
            wr_acks++;
            wr_addr_seen = mem_addr;
            wr_data_seen = mem_wdata;
          end else begin
            mem_rdata = mem_get(mem_addr[31:2]);
            rd_acks++;
          end
        end else begin
          mem_rdata = $urandom;
          wcnt++;
        end
      end
    end
  end

  task automatic run_txn(input string nm, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input int w0, input int w1);
    int          exp_stall, exp_req, exp_rd, exp_wr, exp_err;
    logic [31:0] exp_wdata;
    int          stall_n, req_n, err_n, rd0, wr0, ba0;
    logic        done;
    logic [29:0] idx;
    logic [31:0] old;
    idx       = a[31:2];
    old       = ref_get(idx);
    exp_err   = 0;
    exp_rd    = 0;
    exp_wr    = 0;
    exp_stall = 0;
    exp_wdata = 32'h0;
    if (wr) begin
      if ((sz == SIZE_HALF) && a[0]) begin
        exp_stall = 1;
        exp_err   = 1;
      end else if ((sz == SIZE_BYTE) || (sz == SIZE_HALF)) begin
        if (w0 >= TMO) begin
          exp_stall = 1 + TMO;
          exp_err   = 1;
        end else begin
          exp_rd = 1;
          if (w1 >= TMO) begin
            exp_stall = 2 + w0 + TMO;
            exp_err   = 1;
          end else begin
            exp_stall = 3 + w0 + w1;
            exp_wr    = 1;
            exp_wdata = ref_merge(old, d, a[1:0], sz);
          end
        end
      end else begin
        if (w0 >= TMO) begin
          exp_stall = 1 + TMO;
          exp_err   = 1;
        end else begin
          exp_stall = 2 + w0;
          exp_wr    = 1;
          exp_wdata = d;
        end
      end
    end else begin
      if (w0 >= TMO) begin
        exp_stall = 1 + TMO;
        exp_err   = 1;
      end else begin
        exp_stall = 2 + w0;
        exp_rd    = 1;
        ref_rdata = old;
      end
    end
    exp_req = exp_stall - 1;
    if (exp_wr == 1) ref_mem[idx] = exp_wdata;

    wt[0]    = w0;
    wt[1]    = w1;
    exp_addr = {a[31:2], 2'b00};
    rd0      = rd_acks;
    wr0      = wr_acks;
    ba0      = bad_addr;

    @(posedge CLK); #1;
    MemRead_IN   = rd;
    MemWrite_IN  = wr;
    Address_IN   = a;
    WriteData_IN = d;
    WriteSize_IN = sz;
    stall_n = 0;
    req_n   = 0;
    err_n   = 0;
    done    = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge CLK);
      if (mem_req)   req_n++;
      if (Error_OUT) err_n++;
      if (Stall_OUT) stall_n++;
      else           done = 1'b1;
    end
    chk({nm, ":finished"}, 32'(done), 32'd1);
    chk({nm, ":stall"}, 32'(stall_n), 32'(exp_stall));
    chk({nm, ":req"}, 32'(req_n), 32'(exp_req));
    chk({nm, ":err"}, 32'(err_n), 32'(exp_err));
    chk({nm, ":rdacks"}, 32'(rd_acks - rd0), 32'(exp_rd));
    chk({nm, ":wracks"}, 32'(wr_acks - wr0), 32'(exp_wr));
    chk({nm, ":addr"}, 32'(bad_addr - ba0), 32'd0);
    chk({nm, ":rdata"}, ReadData_OUT, ref_rdata);
    if (exp_wr == 1) begin
      chk({nm, ":waddr"}, wr_addr_seen, exp_addr);
      chk({nm, ":wdata"}, wr_data_seen, exp_wdata);
    end
    chk({nm, ":memword"}, mem_get(idx), ref_get(idx));

    @(posedge CLK); #1;
    MemRead_IN  = 1'b0;
    MemWrite_IN = 1'b0;
    @(negedge CLK);
    chk({nm, ":errpulse"}, 32'(Error_OUT), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    RESET        = 1'b1;
    MemRead_IN   = 1'b0;
    MemWrite_IN  = 1'b0;
    Address_IN   = 32'h0;
    WriteData_IN = 32'h0;
    WriteSize_IN = SIZE_WORD;
    ref_rdata    = 32'h0;
    wt[0]        = 0;
    wt[1]        = 0;
    repeat (3) @(negedge CLK);
    chk("rst:rdata", ReadData_OUT, 32'h0);
    chk("rst:req", 32'(mem_req), 32'd0);
    chk("rst:we", 32'(mem_we), 32'd0);
    chk("rst:addr", mem_addr, 32'h0);
    chk("rst:wdata", mem_wdata, 32'h0);
    chk("rst:err", 32'(Error_OUT), 32'd0);
    chk("rst:stall", 32'(Stall_OUT), 32'd0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    run_txn("t1_load",    1'b1, 1'b0, 32'h00001004, 32'h0,        SIZE_WORD, 0, 0);
    run_txn("t2_byte",    1'b0, 1'b1, 32'h00002002, 32'h000000AB, SIZE_BYTE, 2, 2);
    run_txn("t3_half",    1'b0, 1'b1, 32'h00003000, 32'h0000CAFE, SIZE_HALF, 0, 0);
    run_txn("t3_misal",   1'b0, 1'b1, 32'h00003001, 32'h0000CAFE, SIZE_HALF, 0, 0);
    run_txn("t4_both",    1'b1, 1'b1, 32'h00004003, 32'h12345678, SIZE_WORD, 0, 0);
    run_txn("t5_tmo",     1'b1, 1'b0, 32'h00001008, 32'h0,        SIZE_WORD, 9, 0);
    run_txn("t_rmw_tmo",  1'b0, 1'b1, 32'h00002001, 32'h000000CD, SIZE_BYTE, 1, 7);
    run_txn("t_res_word", 1'b0, 1'b1, 32'h00006000, 32'hA5A55A5A, 2'd3,      1, 0);

    // Reset in the middle of a write phase
    wt[0]    = 50;
    wt[1]    = 50;
    exp_addr = 32'h00005000;
    @(posedge CLK); #1;
    MemWrite_IN  = 1'b1;
    MemRead_IN   = 1'b0;
    Address_IN   = 32'h00005000;
    WriteData_IN = 32'hFEEDF00D;
    WriteSize_IN = SIZE_WORD;
    @(negedge CLK);
    @(negedge CLK);
    chk("t6:req_before", 32'(mem_req), 32'd1);
    chk("t6:we_before", 32'(mem_we), 32'd1);
    chk("t6:stall_before", 32'(Stall_OUT), 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("t6:req_async", 32'(mem_req), 32'd0);
    chk("t6:stall_async", 32'(Stall_OUT), 32'd0);
    chk("t6:err_async", 32'(Error_OUT), 32'd0);
    MemWrite_IN = 1'b0;
    @(negedge CLK);
    RESET     = 1'b0;
    ref_rdata = 32'h0;
    @(negedge CLK);
    chk("t6:rdata_cleared", ReadData_OUT, 32'h0);
    chk("t6:no_write", mem_get(30'(32'h5000 >> 2)), ref_get(30'(32'h5000 >> 2)));
    run_txn("t6_load", 1'b1, 1'b0, 32'h00001004, 32'h0, SIZE_WORD, 1, 0);

    for (int n = 0; n < 150; n++) begin
      int          mode;
      logic        r, w;
      logic [31:0] a, d;
      logic [1:0]  sz;
      int          w0, w1;
      mode = $urandom_range(0, 3);
      r    = (mode == 0) || (mode == 3);
      w    = (mode == 1) || (mode == 2) || (mode == 3);
      a    = 32'h00008000 + 32'($urandom_range(0, 255));
      d    = $urandom;
      sz   = 2'($urandom_range(0, 3));
      w0   = $urandom_range(0, 5);
      w1   = $urandom_range(0, 5);
      run_txn("rand", r, w, a, d, sz, w0, w1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sits directly downstream of the MEM stage, between its data-memory request outputs and the physical data memory. Converts MEM's single-cycle request (address, write data, size, read/write strobes) into a req/ack handshake with a variable-latency memory. Performs read-modify-write for byte and halfword stores and stalls the pipeline until each access completes. Returns the aligned read word to MEM, which does its own byte/half extraction.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles waiting for mem_ack before aborting with error (8-bit counter; legal values 1..255)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
MemRead_IN  in  1  load request from MEM
MemWrite_IN  in  1  store request from MEM
Address_IN  in  32  byte address (MEM data_address_2DM)
WriteData_IN  in  32  store data; for byte/half stores the value is in low bits [7:0]/[15:0]
WriteSize_IN  in  2  0=word, 1=byte, 2=half, 3=reserved (treated as word)
ReadData_OUT  out  32  aligned word from the last completed read
Stall_OUT  out  1  pipeline must hold MEM inputs stable
Error_OUT  out  1  one-cycle pulse: timeout or misaligned access
mem_req  out  1  memory request
mem_we  out  1  1=write, 0=read
mem_addr  out  32  word-aligned address {A[31:2],2'b00}
mem_wdata  out  32  full word to write
mem_ack  in  1  single-cycle completion strobe
mem_rdata  in  32  read word, valid while mem_ack=1

Behaviour:
- Clock is CLK. RESET is asynchronous and active-high. Reset values: state IDLE; ReadData_OUT=0; Error_OUT=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; timeout counter=0.
- Reset asserted mid-transaction aborts the access immediately. mem_req falls asynchronously. No completion or error is reported.
- Byte lanes are big-endian: offset 0 maps to bits [31:24]; offset 3 maps to [7:0].
- States: IDLE, RD, WR, DONE.
- IDLE:
  - If MemWrite_IN=1, latch A=Address_IN, D=WriteData_IN, S=WriteSize_IN.
    - Word store: go to WR.
    - Byte, or half with A[0]=0: go to RD (read phase of a read-modify-write).
  - Else if MemRead_IN=1: latch A, go to RD.
  - If both strobes are asserted, the store wins.
  - A half store with A[0]=1 is misaligned: pulse Error_OUT, go to DONE, no memory access.
- RD: mem_req=1, mem_we=0. On mem_ack:
  - Load: ReadData_OUT<=mem_rdata, go to DONE.
  - Read-modify-write: latch merged word into mem_wdata, go to WR.
  - Merge rule: byte store replaces lane A[1:0] with D[7:0]; half store replaces [31:16] if A[1]=0, else [15:0], with D[15:0].
- WR: mem_req=1, mem_we=1, mem_wdata = D (word store) or the merged word. On mem_ack go to DONE.
- DONE: lasts one cycle, then IDLE. Stall_OUT=0 in this cycle, so the pipeline advances at its closing edge.
- Stall_OUT is combinational: 1 when (IDLE and (MemRead_IN or MemWrite_IN)) or state is RD or WR; otherwise 0.
- mem_req, mem_we, mem_addr and mem_wdata are registered.
  - They are stable for the whole request and mem_req stays high until ack is sampled.
  - mem_req is 0 in the cycle after ack.
- Timeout counter:
  - Clears on entry to RD or WR and increments each cycle without ack.
  - Reaching TIMEOUT_CYCLES drops mem_req, pulses Error_OUT and goes to DONE.
  - A timed-out load leaves ReadData_OUT unchanged. A timed-out RMW performs no write.
- Latency with zero-wait memory (ack in the first req cycle), with the request presented in cycle 0:
  - Load or word store: Stall_OUT high in cycles 0–1; DONE in cycle 2.
  - Byte/half store: Stall_OUT high in cycles 0–2; DONE in cycle 3.
- Each memory wait cycle adds one stall cycle.
- ReadData_OUT holds its value until the next successful read. Stores never change it.

Decomposition:
- Shared package dmem_pkg: state enum (IDLE, RD, WR, DONE); size constants SIZE_WORD=2'd0, SIZE_BYTE=2'd1, SIZE_HALF=2'd2; timeout counter width constant (8).
- One combinational sub-module, dmem_store_merge. Inputs: old word, D, A[1:0], S. Output: merged word. Unit-testable alone.

Test Plan:
1. Load at 0x1004, memory word 0xDEADBEEF, ack in first req cycle -> mem_addr=0x1004, mem_we=0; Stall_OUT high 2 cycles; ReadData_OUT=0xDEADBEEF in DONE.
2. Byte store D=0x000000AB at 0x2002, old word 0x11223344, ack after 2 wait cycles each phase -> read then write to 0x2000 with mem_wdata=0x1122AB44; Stall_OUT high 7 cycles.
3. Half store D=0x0000CAFE at 0x3000, old 0x11223344 -> write 0xCAFE3344. Same at 0x3001 -> Error_OUT pulse, no mem_req, DONE next cycle.
4. Word store 0x12345678 at 0x4003 with MemRead_IN also high -> single write to 0x4000, data 0x12345678, no read phase.
5. Load with mem_ack never asserted, TIMEOUT_CYCLES=4 -> mem_req high exactly 4 cycles, Error_OUT pulse, ReadData_OUT unchanged, state returns to IDLE.
6. RESET asserted mid-WR -> mem_req and Stall_OUT fall without a clock edge; after release, IDLE and a fresh load completes normally.
